muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 130 +++++++++++++
 tb/tb_muldiv_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO architectural registers and a fixed-latency busy window.
// Results are computed in the start cycle and committed to HI/LO when the latency counter expires.
module muldiv_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  MulDivOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] Out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

    logic [3:0]  count_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] pend_hi_r;
    logic [31:0] pend_lo_r;
    logic        pend_wr_r;

    logic        is_mul_s;
    logic        is_div_s;
    logic        start_s;
    logic        div_zero_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [63:0] res_s;

    // Operation decode, start detection and busy.
    always_comb begin
        is_mul_s = (MulDivOp == OP_MULT) || (MulDivOp == OP_MULTU);
        is_div_s = (MulDivOp == OP_DIV) || (MulDivOp == OP_DIVU);
        start_s  = (is_mul_s || is_div_s) && (count_r == 4'd0);
        busy     = start_s || (count_r != 4'd0);
    end

    // Full-width result datapath; signed divide works on magnitudes, then restores signs.
    always_comb begin
        div_zero_s = (B == 32'd0);
        if (MulDivOp == OP_DIV) begin
            abs_a_s = A[31] ? (32'd0 - A) : A;
            abs_b_s = B[31] ? (32'd0 - B) : B;
        end else begin
            abs_a_s = A;
            abs_b_s = B;
        end
        if (div_zero_s) begin
            q_mag_s = 32'd0;
            r_mag_s = 32'd0;
        end else begin
            q_mag_s = abs_a_s / abs_b_s;
            r_mag_s = abs_a_s % abs_b_s;
        end
        case (MulDivOp)
            OP_MULT:  res_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
            OP_MULTU: res_s = {32'd0, A} * {32'd0, B};
            OP_DIV:   res_s = {(A[31] ? (32'd0 - r_mag_s) : r_mag_s),
                               ((A[31] ^ B[31]) ? (32'd0 - q_mag_s) : q_mag_s)};
            OP_DIVU:  res_s = {r_mag_s, q_mag_s};
            default:  res_s = 64'd0;
        endcase
    end

    // MFHI/MFLO read port.
    always_comb begin
        case (MulDivOp)
            OP_MFHI: Out = hi_r;
            OP_MFLO: Out = lo_r;
            default: Out = 32'd0;
        endcase
    end

    // Latency counter, pending result and HI/LO update; moves to HI/LO only when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r   <= 4'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
        end else if (start_s) begin
            pend_hi_r <= res_s[63:32];
            pend_lo_r <= res_s[31:0];
            pend_wr_r <= !(is_div_s && div_zero_s);
            count_r   <= is_mul_s ? MUL_LAT_C : DIV_LAT_C;
        end else if (count_r > 4'd1) begin
            count_r <= count_r - 4'd1;
        end else if (count_r == 4'd1) begin
            count_r <= 4'd0;
            if (pend_wr_r) begin
                hi_r <= pend_hi_r;
                lo_r <= pend_lo_r;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end else begin
            if (MulDivOp == OP_MTHI) begin
                hi_r <= A;
            end else if (MulDivOp == OP_MTLO) begin
                lo_r <= A;
            end else begin
                hi_r <= hi_r;
            end
        end
    end

    assign HI = hi_r;
    assign LO = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized traffic
// compared each cycle against a cycle-count based behavioural model.
module tb_muldiv_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_bad = 0;

    // Reference state: architectural HI/LO, pending result, and the first idle cycle.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_pend_hi = 32'd0;
    logic [31:0] m_pend_lo = 32'd0;
    bit          m_pend = 1'b0;
    int          cyc = 0;
    int          busy_until = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .MulDivOp (op),
        .A        (a),
        .B        (b),
        .busy     (busy),
        .Out      (out),
        .HI       (hi),
        .LO       (lo)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_start_op(input logic [3:0] o);
        return (o >= 4'd1) && (o <= 4'd4);
    endfunction

    task automatic ref_result(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                              output logic [31:0] rh, output logic [31:0] rl, output bit wr);
        longint          sp;
        longint unsigned up;
        int              sx, sy, q, r;
        rh = 32'd0;
        rl = 32'd0;
        wr = 1'b1;
        sx = x;
        sy = y;
        case (o)
            4'd1: begin
                sp = longint'(sx) * longint'(sy);
                rh = sp[63:32];
                rl = sp[31:0];
            end
            4'd2: begin
                up = 64'(x) * 64'(y);
                rh = up[63:32];
                rl = up[31:0];
            end
            4'd3: begin
                if (y == 32'd0) begin
                    wr = 1'b0;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000;
                    rh = 32'd0;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    rl = q;
                    rh = r;
                end
            end
            4'd4: begin
                if (y == 32'd0) begin
                    wr = 1'b0;
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
            default: wr = 1'b0;
        endcase
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance the model across the edge.
    task automatic cycle(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        bit          idle;
        bit          exp_busy;
        logic [31:0] exp_out;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        idle = (cyc >= busy_until);
        exp_busy = idle ? is_start_op(o) : 1'b1;
        exp_out = (o == 4'd5) ? m_hi : ((o == 4'd6) ? m_lo : 32'd0);
        check_val("busy", {31'd0, busy}, {31'd0, exp_busy});
        check_val("out", out, exp_out);
        check_val("hi", hi, m_hi);
        check_val("lo", lo, m_lo);
        if (idle) begin
            if (is_start_op(o)) begin
                ref_result(o, x, y, m_pend_hi, m_pend_lo, m_pend);
                busy_until = cyc + 1 + ((o <= 4'd2) ? MUL_LAT : DIV_LAT);
            end else if (o == 4'd7) begin
                m_hi = x;
            end else if (o == 4'd8) begin
                m_lo = x;
            end
        end
        cyc++;
        if (m_pend && cyc == busy_until) begin
            m_hi = m_pend_hi;
            m_lo = m_pend_lo;
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset applied away from any clock edge.
    task automatic apply_reset();
        op = 4'd0;
        reset_n = 1'b0;
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_pend = 1'b0;
        cyc = 0;
        busy_until = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        apply_reset();

        // Signed multiply of -2 by 3.
        cycle(4'd1, 32'hFFFF_FFFE, 32'd3);
        repeat (MUL_LAT) cycle(4'd0, 32'd0, 32'd0);
        check_val("mult_hi", hi, 32'hFFFF_FFFF);
        check_val("mult_lo", lo, 32'hFFFF_FFFA);

        cycle(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (MUL_LAT) cycle(4'd0, 32'd0, 32'd0);
        check_val("multu_hi", hi, 32'hFFFF_FFFE);
        check_val("multu_lo", lo, 32'h0000_0001);

        cycle(4'd3, 32'hFFFF_FFF9, 32'd2);
        repeat (DIV_LAT) cycle(4'd0, 32'd0, 32'd0);
        check_val("div_lo", lo, 32'hFFFF_FFFD);
        check_val("div_hi", hi, 32'hFFFF_FFFF);

        cycle(4'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (DIV_LAT) cycle(4'd0, 32'd0, 32'd0);
        check_val("divu_lo", lo, 32'h7FFF_FFFC);
        check_val("divu_hi", hi, 32'h0000_0001);

        cycle(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (DIV_LAT) cycle(4'd0, 32'd0, 32'd0);
        check_val("divovf_lo", lo, 32'h8000_0000);
        check_val("divovf_hi", hi, 32'h0000_0000);

        // Divide by zero keeps HI/LO.
        cycle(4'd7, 32'h1234_5678, 32'd0);
        cycle(4'd3, 32'd5, 32'd0);
        repeat (DIV_LAT) cycle(4'd0, 32'd0, 32'd0);
        check_val("div0_hi", hi, 32'h1234_5678);
        op = 4'd5;
        #1;
        check_val("mfhi", out, 32'h1234_5678);
        cycle(4'd5, 32'd0, 32'd0);

        // Reset in cycle 3 of a divide.
        cycle(4'd3, 32'd100, 32'd7);
        cycle(4'd0, 32'd0, 32'd0);
        cycle(4'd0, 32'd0, 32'd0);
        apply_reset();
        repeat (DIV_LAT + 2) cycle(4'd0, 32'd0, 32'd0);
        check_val("abort_hi", hi, 32'd0);
        check_val("abort_lo", lo, 32'd0);

        // Ignored start while busy, ignored MTLO on completion, back-to-back start.
        cycle(4'd1, 32'd3, 32'd4);
        cycle(4'd1, 32'd7, 32'd7);
        cycle(4'd2, 32'd9, 32'd9);
        repeat (MUL_LAT - 3) cycle(4'd0, 32'd0, 32'd0);
        cycle(4'd8, 32'hDEAD_BEEF, 32'd0);
        check_val("b2b_lo", lo, 32'd12);
        cycle(4'd1, 32'd6, 32'd7);
        repeat (MUL_LAT) cycle(4'd0, 32'd0, 32'd0);
        check_val("b2b_lo2", lo, 32'd42);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 30) begin
                rop = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
            end else begin
                rop = 4'($urandom_range(1, 8));
            end
            ra = $urandom;
            rb = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 19) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 19) == 0) rb = 32'hFFFF_FFFF;
            if ($urandom_range(0, 499) == 0) apply_reset();
            cycle(rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
